// File: rtl/dmac_pkg.sv
// Shared constants for the DMAC register file: register word offsets, field positions and
// the AHB transfer-type encodings the slave reacts to.
package dmac_pkg;

  // Offsets are word indices, i.e. HADDR[5:2].
  localparam logic [3:0] CTRL_OFF    = 4'h0;
  localparam logic [3:0] SADDR_OFF   = 4'h1;
  localparam logic [3:0] DADDR_OFF   = 4'h2;
  localparam logic [3:0] SIZE_OFF    = 4'h3;
  localparam logic [3:0] INC_OFF     = 4'h4;
  localparam logic [3:0] BCFG_OFF    = 4'h5;
  localparam logic [3:0] ICRADDR_OFF = 4'h6;
  localparam logic [3:0] ICR_OFF     = 4'h7;
  localparam logic [3:0] STATUS_OFF  = 4'h8;
  localparam logic [3:0] IE_OFF      = 4'h9;

  localparam int unsigned GO_BIT     = 0;
  localparam int unsigned WFI_BIT    = 1;
  localparam int unsigned IRQSRC_LSB = 4;
  localparam int unsigned SSIZE_LSB  = 0;
  localparam int unsigned DSIZE_LSB  = 4;
  localparam int unsigned SINC_LSB   = 0;
  localparam int unsigned DINC_LSB   = 4;
  localparam int unsigned BSIZE_LSB  = 0;
  localparam int unsigned BCOUNT_LSB = 8;
  localparam int unsigned BUSY_BIT   = 0;
  localparam int unsigned DONE_BIT   = 1;
  localparam int unsigned IE_BIT     = 0;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Channel configuration registers, the ones frozen while the engine is busy.
  function automatic logic is_cfg_reg(logic [3:0] idx);
    return idx <= ICR_OFF;
  endfunction

endpackage

// File: rtl/dmac_sync.sv
// Multi-stage flop synchroniser, one independent chain per bit, level passing.
module dmac_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Stages];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Stages; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < Stages; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[Stages-1];

endmodule

// File: rtl/dmac_ahbl_regs.sv
// AHB-Lite register file in front of the DMAC engine: channel config, start pulse,
// synchronised peripheral IRQs and the sticky done status / interrupt.
module dmac_ahbl_regs
  import dmac_pkg::*;
#(
  parameter int unsigned NPIRQ = 8,
  parameter int unsigned SYNC  = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic [31:0]      saddr,
  output logic [31:0]      daddr,
  output logic [31:0]      icr_addr,
  output logic [31:0]      icr,
  output logic [2:0]       ssize,
  output logic [2:0]       dsize,
  output logic [2:0]       sinc,
  output logic [2:0]       dinc,
  output logic [2:0]       irqsrc,
  output logic [7:0]       bsize,
  output logic [7:0]       bcount,
  output logic             wfi,
  output logic             start,
  output logic [NPIRQ-1:0] pirq,
  input  logic [NPIRQ-1:0] pirq_async,
  input  logic             done,
  input  logic             busy,
  output logic             irq
);

  logic        valid_q, write_q;
  logic [3:0]  addr_q;
  logic [31:0] saddr_q, daddr_q, icr_addr_q, icr_q;
  logic [2:0]  ssize_q, dsize_q, sinc_q, dinc_q, irqsrc_q;
  logic [7:0]  bsize_q, bcount_q;
  logic        wfi_q, start_q, done_st_q, ie_q, irq_q;
  logic        wr_en, cfg_we, start_d, done_st_d, ie_d;
  logic        unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:6], HADDR[1:0]};
  assign HREADYOUT   = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (HREADY) begin
      valid_q <= HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
      write_q <= HWRITE;
      addr_q  <= HADDR[5:2];
    end
  end

  always_comb begin
    wr_en     = valid_q & write_q;
    // busy is sampled at the data-phase edge; GO is dropped along with the config.
    cfg_we    = wr_en & ~busy & is_cfg_reg(addr_q);
    start_d   = cfg_we & (addr_q == CTRL_OFF) & HWDATA[GO_BIT];
    // A done pulse wins over a coincident write-1-to-clear.
    done_st_d = done |
                (done_st_q & ~(wr_en & (addr_q == STATUS_OFF) & HWDATA[DONE_BIT]));
    ie_d      = (wr_en && addr_q == IE_OFF) ? HWDATA[IE_BIT] : ie_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      saddr_q    <= '0;
      daddr_q    <= '0;
      icr_addr_q <= '0;
      icr_q      <= '0;
      ssize_q    <= '0;
      dsize_q    <= '0;
      sinc_q     <= '0;
      dinc_q     <= '0;
      irqsrc_q   <= '0;
      bsize_q    <= '0;
      bcount_q   <= '0;
      wfi_q      <= 1'b0;
      start_q    <= 1'b0;
      done_st_q  <= 1'b0;
      ie_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (addr_q)
          CTRL_OFF: begin
            wfi_q    <= HWDATA[WFI_BIT];
            irqsrc_q <= HWDATA[IRQSRC_LSB +: 3];
          end
          SADDR_OFF: saddr_q <= HWDATA;
          DADDR_OFF: daddr_q <= HWDATA;
          SIZE_OFF: begin
            ssize_q <= HWDATA[SSIZE_LSB +: 3];
            dsize_q <= HWDATA[DSIZE_LSB +: 3];
          end
          INC_OFF: begin
            sinc_q <= HWDATA[SINC_LSB +: 3];
            dinc_q <= HWDATA[DINC_LSB +: 3];
          end
          BCFG_OFF: begin
            bsize_q  <= HWDATA[BSIZE_LSB +: 8];
            bcount_q <= HWDATA[BCOUNT_LSB +: 8];
          end
          ICRADDR_OFF: icr_addr_q <= HWDATA;
          ICR_OFF:     icr_q      <= HWDATA;
          default: ;
        endcase
      end
      start_q   <= start_d;
      done_st_q <= done_st_d;
      ie_q      <= ie_d;
      irq_q     <= done_st_d & ie_d;
    end
  end

  always_comb begin
    HRDATA = '0;
    case (addr_q)
      CTRL_OFF: begin
        HRDATA[WFI_BIT]           = wfi_q;
        HRDATA[IRQSRC_LSB +: 3]   = irqsrc_q;
      end
      SADDR_OFF: HRDATA = saddr_q;
      DADDR_OFF: HRDATA = daddr_q;
      SIZE_OFF: begin
        HRDATA[SSIZE_LSB +: 3]    = ssize_q;
        HRDATA[DSIZE_LSB +: 3]    = dsize_q;
      end
      INC_OFF: begin
        HRDATA[SINC_LSB +: 3]     = sinc_q;
        HRDATA[DINC_LSB +: 3]     = dinc_q;
      end
      BCFG_OFF: begin
        HRDATA[BSIZE_LSB +: 8]    = bsize_q;
        HRDATA[BCOUNT_LSB +: 8]   = bcount_q;
      end
      ICRADDR_OFF: HRDATA = icr_addr_q;
      ICR_OFF:     HRDATA = icr_q;
      STATUS_OFF: begin
        HRDATA[BUSY_BIT]          = busy;
        HRDATA[DONE_BIT]          = done_st_q;
      end
      IE_OFF: HRDATA[IE_BIT] = ie_q;
      default: ;
    endcase
  end

  dmac_sync #(
    .Width (NPIRQ),
    .Stages(SYNC)
  ) u_pirq_sync (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .d    (pirq_async),
    .q    (pirq)
  );

  assign saddr    = saddr_q;
  assign daddr    = daddr_q;
  assign icr_addr = icr_addr_q;
  assign icr      = icr_q;
  assign ssize    = ssize_q;
  assign dsize    = dsize_q;
  assign sinc     = sinc_q;
  assign dinc     = dinc_q;
  assign irqsrc   = irqsrc_q;
  assign bsize    = bsize_q;
  assign bcount   = bcount_q;
  assign wfi      = wfi_q;
  assign start    = start_q;
  assign irq      = irq_q;

endmodule
